// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the CPU native-memory-bus mux and its helpers:
//   - MEM_DATA_W      : bus data width
//   - DEFAULT_RDATA_C : read data returned on unmapped / timed-out accesses
//   - bus_state_t     : transaction FSM encoding (IDLE/BUSY/RESP/RECOVER)
//   - sel_width()     : width of a device index for a given device count
// ---------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int MEM_DATA_W = 32;

  localparam logic [MEM_DATA_W-1:0] DEFAULT_RDATA_C = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } bus_state_t;

  // A single device still needs a 1-bit index so port widths stay legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_prio_enc.sv
// ---------------------------------------------------------------------------
// mem_bus_prio_enc
// Combinational priority encoder over a per-device decode vector.
//   i_decode : one bit per device, bit i = device i hit
//   o_idx    : index of the lowest set bit (0 when none set)
//   o_any    : at least one bit set
//   o_multi  : more than one bit set
// ---------------------------------------------------------------------------
module mem_bus_prio_enc
  import mem_bus_pkg::*;
#(
  parameter int N_DEV = 2
) (
  input  logic [N_DEV-1:0]            i_decode,
  output logic [sel_width(N_DEV)-1:0] o_idx,
  output logic                        o_any,
  output logic                        o_multi
);

  localparam int SEL_W = sel_width(N_DEV);

  // Walk from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (i_decode[i]) o_idx = SEL_W'(i);
    end
  end

  assign o_any   = |i_decode;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_decode & (i_decode - N_DEV'(1)));

endmodule

// File: rtl/mem_bus_mux.sv
// ---------------------------------------------------------------------------
// mem_bus_mux
// Registered CPU native-memory-bus mux: routes one request to one of N_DEV
// devices chosen by per-device decode lines, and answers with DEFAULT_RDATA
// plus an error pulse on unmapped accesses or device timeouts.
//
// Handshake: a request is held by cpu_mem_valid until the one-cycle
// cpu_mem_ready pulse; dev_mem_valid[sel] is held until dev_mem_ready[sel]
// is seen high on a rising edge. At most one transaction is outstanding.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   cpu_mem_valid    CPU request valid
//   cpu_mem_ready    one-cycle response pulse
//   cpu_mem_wstrb    0 = read; only recorded for error accounting
//   cpu_mem_rdata    registered read data, valid with cpu_mem_ready
//   dev_decode       per-device address hit
//   dev_mem_valid    one-hot device request (only in BUSY)
//   dev_mem_ready    per-device ready
//   dev_mem_rdata    device i on bits [32i+31:32i]
//   err_unmapped     pulse with an unmapped-access response
//   err_timeout      pulse with a timeout response
//   err_multihit     (MEM_BUS_MUX_MULTIHIT_CHECK_EN only) multi-decode pulse
//   o_dbg_state      current FSM state
//   o_dbg_multihit   live "more than one decode bit set" flag
//   o_dbg_err_write  last error response was for a write
//
// Build option: define MEM_BUS_MUX_MULTIHIT_CHECK_EN to treat multiple decode
// hits as unmapped and add the err_multihit output.
// ---------------------------------------------------------------------------
module mem_bus_mux
  import mem_bus_pkg::*;
#(
  parameter int                     N_DEV          = 2,
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [MEM_DATA_W-1:0]  DEFAULT_RDATA  = DEFAULT_RDATA_C
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cpu_mem_valid,
  output logic                        cpu_mem_ready,
  input  logic [3:0]                  cpu_mem_wstrb,
  output logic [MEM_DATA_W-1:0]       cpu_mem_rdata,
  input  logic [N_DEV-1:0]            dev_decode,
  output logic [N_DEV-1:0]            dev_mem_valid,
  input  logic [N_DEV-1:0]            dev_mem_ready,
  input  logic [MEM_DATA_W*N_DEV-1:0] dev_mem_rdata,
  output logic                        err_unmapped,
  output logic                        err_timeout,
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
  output logic                        err_multihit,
`endif
  output logic [1:0]                  o_dbg_state,
  output logic                        o_dbg_multihit,
  output logic                        o_dbg_err_write
);

  localparam int SEL_W = sel_width(N_DEV);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bus_state_t            r_state, w_next;
  logic [SEL_W-1:0]      r_sel, w_sel_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [MEM_DATA_W-1:0] r_rdata, w_rdata_next;
  logic                  r_err_unm, w_err_unm_next;
  logic                  r_err_to, w_err_to_next;
  logic                  r_err_wr, w_err_wr_next;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
  logic                  r_err_mh, w_err_mh_next;
`endif

  logic [SEL_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_multi;
  logic                  w_unmapped;
  logic                  w_rdy_sel;
  logic [MEM_DATA_W-1:0] w_rdata_sel;
  logic                  w_timeout;

  mem_bus_prio_enc #(.N_DEV(N_DEV)) u_prio_enc (
    .i_decode (dev_decode),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_multi  (w_multi)
  );

`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
  assign w_unmapped = !w_any || w_multi;
`else
  assign w_unmapped = !w_any;
`endif

  assign w_rdy_sel   = dev_mem_ready[r_sel];
  assign w_rdata_sel = dev_mem_rdata[MEM_DATA_W*int'(r_sel) +: MEM_DATA_W];
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err_unm <= 1'b0;
      r_err_to  <= 1'b0;
      r_err_wr  <= 1'b0;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
      r_err_mh  <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_sel     <= w_sel_next;
      r_cnt     <= w_cnt_next;
      r_rdata   <= w_rdata_next;
      r_err_unm <= w_err_unm_next;
      r_err_to  <= w_err_to_next;
      r_err_wr  <= w_err_wr_next;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
      r_err_mh  <= w_err_mh_next;
`endif
    end
  end

  // Error flags are only set on the edge that enters RESP, so they line up
  // with the single cpu_mem_ready cycle.
  always_comb begin
    w_next         = r_state;
    w_sel_next     = r_sel;
    w_cnt_next     = r_cnt;
    w_rdata_next   = r_rdata;
    w_err_unm_next = 1'b0;
    w_err_to_next  = 1'b0;
    w_err_wr_next  = r_err_wr;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
    w_err_mh_next  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (cpu_mem_valid) begin
          if (w_unmapped) begin
            w_rdata_next   = DEFAULT_RDATA;
            w_err_unm_next = 1'b1;
            w_err_wr_next  = |cpu_mem_wstrb;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
            w_err_mh_next  = w_multi;
`endif
            w_next         = RESP;
          end else begin
            w_sel_next = w_idx;
            w_cnt_next = '0;
            w_next     = BUSY;
          end
        end
      end
      BUSY: begin
        if (!cpu_mem_valid) begin
          w_next = IDLE;
        end else if (w_rdy_sel) begin
          // Ready beats a coincident timeout.
          w_rdata_next = w_rdata_sel;
          w_next       = RESP;
        end else if (w_timeout) begin
          w_rdata_next  = DEFAULT_RDATA;
          w_err_to_next = 1'b1;
          w_err_wr_next = |cpu_mem_wstrb;
          w_next        = RESP;
        end else if (r_cnt != '1) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        w_next = RECOVER;
      end
      RECOVER: begin
        // Wait out a lingering device ready so it cannot complete the next
        // transaction with stale data.
        if (!cpu_mem_valid && !w_rdy_sel) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Device request decoded purely from registered state: glitch-free, one-hot.
  always_comb begin
    dev_mem_valid = '0;
    if (r_state == BUSY) dev_mem_valid[r_sel] = 1'b1;
  end

  assign cpu_mem_ready   = (r_state == RESP);
  assign cpu_mem_rdata   = r_rdata;
  assign err_unmapped    = r_err_unm;
  assign err_timeout     = r_err_to;
`ifdef MEM_BUS_MUX_MULTIHIT_CHECK_EN
  assign err_multihit    = r_err_mh;
`endif
  assign o_dbg_state     = r_state;
  assign o_dbg_multihit  = w_multi;
  assign o_dbg_err_write = r_err_wr;

endmodule

// File: doc/mem_bus_mux.md
Name: mem_bus_mux

Overview:
- Parametrised, registered successor to the picorv32 native-memory-bus address decoder.
- Routes one CPU request to one of N_DEV devices, chosen by per-device decode lines.
- Tracks each transaction with an FSM.
- Returns DEFAULT_RDATA and an error pulse on unmapped accesses and on device timeouts, so a missing or hung peripheral cannot stall the CPU.

Parameters:
- N_DEV, 2, number of device ports (1..16).
- TIMEOUT_CYCLES, 255, cycles in BUSY before forced error response; 0 disables the timeout.
- DEFAULT_RDATA, 32'hFFFF_FFFF, rdata returned on unmapped or timed-out access.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_mem_valid  in  1  CPU request valid.
- cpu_mem_ready  out  1  one-cycle response pulse to CPU.
- cpu_mem_wstrb  in  4  0 = read; used only for error accounting.
- cpu_mem_rdata  out  32  registered read data, valid while cpu_mem_ready = 1.
- dev_decode  in  N_DEV  per-device address hit, bit i = device i.
- dev_mem_valid  out  N_DEV  one-hot request to the selected device.
- dev_mem_ready  in  N_DEV  per-device ready.
- dev_mem_rdata  in  32*N_DEV  device i on bits [32i+31:32i].
- err_unmapped  out  1  one-cycle pulse, coincident with the error response.
- err_timeout  out  1  one-cycle pulse, coincident with the error response.

Note: addr, wdata and wstrb fan out directly from the CPU to the devices; they are not routed through this block.

Behaviour:
- Reset (async assert, sync deassert by the user): state = IDLE, sel = 0, timeout counter = 0; all outputs 0, cpu_mem_rdata = 0.
- Reset mid-transaction aborts it immediately; no response is issued.
- States: IDLE, BUSY, RESP, RECOVER.
- IDLE:
  - On cpu_mem_valid with any dev_decode bit set: latch sel = lowest set index, clear counter, go BUSY.
  - On cpu_mem_valid with no bit set: load rdata = DEFAULT_RDATA, pulse err_unmapped, go RESP.
- BUSY:
  - dev_mem_valid[sel] = 1 (decoded from registered state; glitch-free); all other bits 0.
  - On dev_mem_ready[sel] = 1: capture dev_mem_rdata[sel] into cpu_mem_rdata, go RESP.
  - Otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: load DEFAULT_RDATA, pulse err_timeout, go RESP.
  - Otherwise counter increments (saturating width clog2(TIMEOUT_CYCLES+1)).
  - Ready and timeout on the same edge: ready wins, no error.
  - cpu_mem_valid dropping in BUSY (protocol violation): return to IDLE, no cpu_mem_ready.
- RESP: cpu_mem_ready = 1 for exactly one cycle; dev_mem_valid = 0; go RECOVER.
- RECOVER: stay until cpu_mem_valid = 0 and dev_mem_ready[sel] = 0, then IDLE.
  - Prevents a device's lingering ready from being taken as the next transaction's response.
- Latency:
  - Unmapped access: cpu_mem_ready in the cycle after the edge that sampled valid.
  - Device with 1-cycle registered ready: cpu_mem_ready 3 cycles after valid is sampled.
- Back-to-back requests are accepted once RECOVER exits; at most one outstanding transaction.
- dev_mem_valid is never asserted for more than one device.
- dev_mem_valid is never asserted outside BUSY.

Optional Feature:
- Macro: MEM_BUS_MUX_MULTIHIT_CHECK_EN.
- Defined:
  - Adds output err_multihit (1 bit).
  - In IDLE, more than one dev_decode bit set is treated as unmapped: DEFAULT_RDATA, err_unmapped and err_multihit pulse together, no device is accessed.
- Undefined: the lowest-index hit wins silently; the port is absent.

Decomposition:
- Package mem_bus_pkg:
  - FSM state encoding (2-bit localparams IDLE = 0, BUSY = 1, RESP = 2, RECOVER = 3).
  - Bus width constant MEM_DATA_W = 32.
  - Default DEFAULT_RDATA value.
- One sub-module: mem_bus_prio_enc.
  - Parametrised by N_DEV.
  - Input: decode vector. Outputs: lowest set index, any-hit flag, multi-hit flag.
  - Combinational, reused by the future DMA arbiter.

Test Plan:
- Read hit: N_DEV = 2, device 0 counter readable at 0x20004000, 1-cycle ready, valid at cycle 10 -> cpu_mem_ready at cycle 13, rdata = d0 counter value; dev_mem_valid[1] never set.
- Write/read-back: write 42042 to device 1 register 0x20005120 (wstrb 4'b1111), then read it back -> first cpu_mem_ready pulse, then rdata = 42042; device 0 register 0x20004048 still 0xAA.
- Unmapped: addr 0x30000000 -> cpu_mem_ready 1 cycle after valid, rdata = 0xFFFFFFFF, err_unmapped = 1 for one cycle, dev_mem_valid = 0 throughout.
- Timeout: TIMEOUT_CYCLES = 8, device 1 never readies -> dev_mem_valid[1] high exactly 8 cycles, then cpu_mem_ready, rdata = 0xFFFFFFFF, err_timeout pulse; next read of device 0 succeeds normally.
- Lingering ready: device 0 holds ready 2 cycles after valid drops, back-to-back read issued -> second transaction waits in RECOVER and returns the second read's data, not stale data.
- Reset mid-BUSY: resetn low while dev_mem_valid[0] = 1 -> all outputs 0 asynchronously; after release the first read completes correctly; with MEM_BUS_MUX_MULTIHIT_CHECK_EN, both decode bits set -> err_multihit and err_unmapped pulse.
